// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with enable prescaler, parallel load,
// synchronous clear, wrap-or-saturate boundary handling and boundary pulse.
module mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int unsigned     SATURATE = 0,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             boundary,
  output logic             at_max,
  output logic             at_zero
);

  localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  // Reject configurations the counter cannot represent.
  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("mod_counter: WIDTH must be within 2..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS must be within 2..2^WIDTH");
    end
    if (SATURATE > 1) begin : g_bad_saturate
      $error("mod_counter: SATURATE must be 0 or 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("mod_counter: PRESCALE must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_boundary;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_step;
  logic             w_hit;
  logic [PW-1:0]    w_next_pre;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_step_count;

  // Next-state decode; a step at the boundary either wraps or holds.
  always_comb begin
    w_at_max     = (r_count == MAX_VAL);
    w_at_zero    = (r_count == '0);
    w_step       = enable && (r_pre == PS_LAST);
    w_next_pre   = (r_pre == PS_LAST) ? '0 : r_pre + PW'(1);
    w_load_val   = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    w_hit        = 1'b0;
    w_step_count = r_count;
    if (up_down) begin
      if (w_at_max) begin
        w_hit        = 1'b1;
        w_step_count = (SATURATE != 0) ? r_count : '0;
      end else begin
        w_step_count = r_count + WIDTH'(1);
      end
    end else begin
      if (w_at_zero) begin
        w_hit        = 1'b1;
        w_step_count = (SATURATE != 0) ? r_count : MAX_VAL;
      end else begin
        w_step_count = r_count - WIDTH'(1);
      end
    end
  end

  // Priority: reset > clear > load > enabled prescale/step.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count    <= '0;
      r_pre      <= '0;
      r_boundary <= 1'b0;
    end else if (load) begin
      r_count    <= w_load_val;
      r_pre      <= '0;
      r_boundary <= 1'b0;
    end else begin
      r_boundary <= w_step && w_hit;
      if (enable) begin
        r_pre <= w_next_pre;
      end
      if (w_step) begin
        r_count <= w_step_count;
      end
    end
  end

  always_comb begin
    counter_out = r_count;
    boundary    = r_boundary;
    at_max      = w_at_max;
    at_zero     = w_at_zero;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the team's fixed 4-bit up-counter.
- Adds configurable width, modulus, up/down direction, parallel load, synchronous clear, a saturate-or-wrap mode, and an enable prescaler.
- Provides boundary and terminal-count indications.
- Serves as the general-purpose timer/index counter for datapath sequencing and timeout logic.

Parameters:
- WIDTH, 8, counter bit width; legal range 2..32.
- MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0, boundary mode: 0 = wrap at the boundary, 1 = hold at the boundary.
- PRESCALE, 1, number of enabled cycles per count step; legal minimum 1. A value of 1 means one step per enabled cycle.

Ports:
- clock, input, 1, sole clock; all state changes on its rising edge.
- reset, input, 1, synchronous, active-high; highest priority.
- enable, input, 1, advances the prescaler, and the count on a prescaler terminal.
- up_down, input, 1, direction: 1 = increment, 0 = decrement; sampled on each step.
- clear, input, 1, synchronous clear of count and prescaler.
- load, input, 1, synchronous parallel load.
- load_value, input, WIDTH, value applied on load.
- counter_out, output, WIDTH, registered count.
- boundary, output, 1, registered single-cycle pulse; see below.
- at_max, output, 1, high when counter_out == MODULUS-1.
- at_zero, output, 1, high when counter_out == 0.

Behaviour:
- Reset state: counter_out = 0, internal prescaler = 0, boundary = 0. Consequently at_zero = 1 and at_max = 0.
- Priority, evaluated each rising edge: reset > clear > load > step.
  - reset or clear: count and prescaler go to 0; boundary goes to 0.
  - load: counter_out takes min(load_value, MODULUS-1); prescaler goes to 0; boundary goes to 0. The same-cycle enable is ignored.
- Prescaler: internal counter of clog2(PRESCALE) bits, minimum 1 bit.
  - With enable = 1 and prescaler < PRESCALE-1: prescaler increments and no step occurs.
  - With enable = 1 and prescaler == PRESCALE-1: prescaler goes to 0 and a step occurs.
  - With enable = 0: prescaler and count both hold.
  - Changing up_down does not reset the prescaler.
- Step, up direction:
  - counter_out < MODULUS-1: counter_out + 1.
  - counter_out == MODULUS-1: becomes 0 if SATURATE = 0; holds if SATURATE = 1.
- Step, down direction:
  - counter_out > 0: counter_out - 1.
  - counter_out == 0: becomes MODULUS-1 if SATURATE = 0; holds if SATURATE = 1.
- Width arithmetic: no carry or borrow ever appears on counter_out. When MODULUS == 2^WIDTH, wrap is natural modular arithmetic.
- boundary pulse:
  - Asserts for exactly one cycle, in the cycle after a step taken while at the boundary for the current direction (at_max when up, at_zero when down). It is therefore aligned with the post-step counter_out.
  - In wrap mode this marks a wrap; in saturate mode it marks a blocked step.
  - Repeated blocked steps in saturate mode produce repeated pulses, one per step.
  - boundary is 0 in every cycle without such a step.
- at_max and at_zero are purely combinational decodes of counter_out. There is no extra latency.
- Latency: with PRESCALE = 1, counter_out reflects an enabled step one clock later. With PRESCALE = N, the first step follows N consecutive enabled edges after reset, clear or load.
- Reset or clear mid-prescale discards the accumulated prescaler count.
- Elaboration: out-of-range parameters cause an elaboration error.

Test Plan:
1. WIDTH=4, MODULUS=16, SATURATE=0, PRESCALE=1; reset, then enable=1, up_down=1 for 17 cycles.
   - counter_out runs 0..15 then 0.
   - boundary pulses once, in the cycle counter_out returns to 0.
   - at_max is high only at 15.
2. MODULUS=10, SATURATE=0; count down from reset for 3 cycles.
   - counter_out goes 0 -> 9 -> 8 -> 7.
   - boundary is high only in the cycle showing 9.
3. MODULUS=10, SATURATE=1; load 8, then count up 4 cycles.
   - counter_out goes 8, 9, 9, 9, 9.
   - boundary pulses on each of the 3 blocked-step cycles.
   - Then count down: 9 -> 8, with no pulse.
4. PRESCALE=3, MODULUS=16; enable=1 continuously from reset.
   - counter_out increments on every 3rd edge: 0,0,1,1,1,2...
   - Drop enable for 2 cycles mid-prescale: prescaler and count hold, and stepping resumes with the prescaler phase preserved.
5. Priority: in one cycle assert load=1 (load_value=5), clear=1 and enable=1 → counter_out=0. Next cycle load=1 alone → 5. Then reset and load together → 0.
6. load_value=12 with MODULUS=10 → counter_out=9 and at_max=1. Reset asserted mid-count with PRESCALE=3 → count 0, and the next step occurs after 3 enabled edges.
